// File: rtl/dot_product_3x3_if.sv
// Host-side word stream and product output of the 3x3 matrix-product engine.
// The host drives the phase select and load words, and the engine returns products and the slot index.
interface dot_product_3x3_if;
    logic        data_RW;
    logic [31:0] in;
    logic [31:0] out;
    logic [3:0]  sel_wire;

    modport master (
        output data_RW,
        output in,
        input  out,
        input  sel_wire
    );

    modport slave (
        input  data_RW,
        input  in,
        output out,
        output sel_wire
    );
endinterface

// File: rtl/dot_product_3x3.sv
// Two-phase 3x3 unsigned matrix-product engine. It loads nine packed A/B element pairs,
// then emits the elements of C = A x B in row-major order, one per clock.
module dot_product_3x3 (
    input logic              clk,
    input logic              reset,
    dot_product_3x3_if.slave bus
);
    localparam logic [3:0] LAST_SLOT = 4'd8;

    logic [31:0] slot_q [9];
    logic [31:0] slot_d [9];
    logic [3:0]  cnt_q;
    logic [3:0]  cnt_d;
    logic        mode_q;
    logic        mode_d;
    logic [31:0] out_q;
    logic [31:0] out_d;

    logic [3:0]  cur_s;
    logic [1:0]  row_s;
    logic [1:0]  col_s;
    logic [15:0] a0_s, a1_s, a2_s;
    logic [15:0] b0_s, b1_s, b2_s;
    logic [31:0] dot_s;

    function automatic logic [31:0] mul16(input logic [15:0] a, input logic [15:0] b);
        return {16'd0, a} * {16'd0, b};
    endfunction

    // Slot used by this edge; a phase change restarts the count at zero.
    always_comb begin
        cur_s = cnt_q;
        if (bus.data_RW != mode_q) begin
            cur_s = 4'd0;
        end else begin
            cur_s = cnt_q;
        end
    end

    // Decode the slot index into the row and column of C.
    always_comb begin
        row_s = 2'd0;
        col_s = 2'd0;
        case (cur_s)
            4'd0:    begin row_s = 2'd0; col_s = 2'd0; end
            4'd1:    begin row_s = 2'd0; col_s = 2'd1; end
            4'd2:    begin row_s = 2'd0; col_s = 2'd2; end
            4'd3:    begin row_s = 2'd1; col_s = 2'd0; end
            4'd4:    begin row_s = 2'd1; col_s = 2'd1; end
            4'd5:    begin row_s = 2'd1; col_s = 2'd2; end
            4'd6:    begin row_s = 2'd2; col_s = 2'd0; end
            4'd7:    begin row_s = 2'd2; col_s = 2'd1; end
            4'd8:    begin row_s = 2'd2; col_s = 2'd2; end
            default: begin row_s = 2'd0; col_s = 2'd0; end
        endcase
    end

    // Pick row i of A (low halves) and column j of B (high halves), then form the dot product.
    always_comb begin
        a0_s = 16'd0; a1_s = 16'd0; a2_s = 16'd0;
        b0_s = 16'd0; b1_s = 16'd0; b2_s = 16'd0;
        case (row_s)
            2'd0:    begin a0_s = slot_q[0][15:0]; a1_s = slot_q[1][15:0]; a2_s = slot_q[2][15:0]; end
            2'd1:    begin a0_s = slot_q[3][15:0]; a1_s = slot_q[4][15:0]; a2_s = slot_q[5][15:0]; end
            2'd2:    begin a0_s = slot_q[6][15:0]; a1_s = slot_q[7][15:0]; a2_s = slot_q[8][15:0]; end
            default: begin a0_s = 16'd0;           a1_s = 16'd0;           a2_s = 16'd0;           end
        endcase
        case (col_s)
            2'd0:    begin b0_s = slot_q[0][31:16]; b1_s = slot_q[3][31:16]; b2_s = slot_q[6][31:16]; end
            2'd1:    begin b0_s = slot_q[1][31:16]; b1_s = slot_q[4][31:16]; b2_s = slot_q[7][31:16]; end
            2'd2:    begin b0_s = slot_q[2][31:16]; b1_s = slot_q[5][31:16]; b2_s = slot_q[8][31:16]; end
            default: begin b0_s = 16'd0;            b1_s = 16'd0;            b2_s = 16'd0;            end
        endcase
        dot_s = mul16(a0_s, b0_s) + mul16(a1_s, b1_s) + mul16(a2_s, b2_s);
    end

    // Next-state: write the slot during load, register the product during compute.
    always_comb begin
        mode_d = bus.data_RW;
        cnt_d  = 4'd0;
        out_d  = out_q;
        if (cur_s >= LAST_SLOT) begin
            cnt_d = 4'd0;
        end else begin
            cnt_d = cur_s + 4'd1;
        end
        for (int s = 0; s < 9; s++) begin
            if (bus.data_RW && (cur_s == s[3:0])) begin
                slot_d[s] = bus.in;
            end else begin
                slot_d[s] = slot_q[s];
            end
        end
        if (bus.data_RW) begin
            out_d = out_q;
        end else begin
            out_d = dot_s;
        end
    end

    // State registers; reset leaves the block in load phase with empty storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= 4'd0;
            mode_q <= 1'b1;
            out_q  <= 32'd0;
            for (int s = 0; s < 9; s++) begin
                slot_q[s] <= 32'd0;
            end
        end else begin
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
            out_q  <= out_d;
            for (int s = 0; s < 9; s++) begin
                slot_q[s] <= slot_d[s];
            end
        end
    end

    assign bus.out      = out_q;
    assign bus.sel_wire = cnt_q;
endmodule

// File: tb/tb_dot_product_3x3.sv
// Scoreboard bench for dot_product_3x3: a behavioural model queues expected products at drive time
// and they are compared when the registered output appears.
module tb_dot_product_3x3;
    logic clk;
    logic reset;
    dot_product_3x3_if bus ();

    dot_product_3x3 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q [$];
    logic [31:0] m_slot [9];
    int          m_cnt;
    logic        m_mode;
    logic [31:0] m_out;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] model_c(input int idx);
        int          row;
        int          col;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] s;
        row = idx / 3;
        col = idx % 3;
        s = 32'd0;
        for (int k = 0; k < 3; k++) begin
            a = {16'd0, m_slot[row*3 + k][15:0]};
            b = {16'd0, m_slot[k*3 + col][31:16]};
            s = s + a * b;
        end
        return s;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 9; s++) m_slot[s] = 32'd0;
        m_cnt  = 0;
        m_mode = 1'b1;
        m_out  = 32'd0;
        exp_q.delete();
    endtask

    // Called #1 after an edge: pulses reset asynchronously and checks the cleared outputs.
    task automatic pulse_reset(input string tag);
        reset = 1'b0;
        #2;
        check_val({tag, "_out"}, bus.out, 32'd0);
        check_val({tag, "_sel"}, {28'd0, bus.sel_wire}, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic step(input logic rw, input logic [31:0] word);
        int eff;
        bus.data_RW = rw;
        bus.in      = word;
        eff = (rw != m_mode) ? 0 : m_cnt;
        m_mode = rw;
        if (rw) begin
            m_slot[eff] = word;
        end else begin
            m_out = model_c(eff);
            exp_q.push_back(m_out);
        end
        m_cnt = (eff == 8) ? 0 : eff + 1;
        @(posedge clk);
        #1;
        check_val("sel", {28'd0, bus.sel_wire}, m_cnt[31:0]);
        if (!rw) begin
            if (exp_q.size() > 0) check_val("out", bus.out, exp_q.pop_front());
        end else begin
            check_val("out_hold", bus.out, m_out);
        end
    endtask

    logic [31:0] plan_c [10] = '{32'd300, 32'd279, 32'd258, 32'd174, 32'd162,
                                 32'd150, 32'd48, 32'd45, 32'd42, 32'd300};

    initial begin
        reset       = 1'b1;
        bus.data_RW = 1'b1;
        bus.in      = 32'd0;
        #1;
        pulse_reset("rst_init");

        // Reset mid-load discards data; compute then yields zero everywhere.
        for (int i = 0; i < 5; i++) step(1'b1, 32'h0003_0002 + i[31:0]);
        pulse_reset("rst_mid");
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 32'hDEAD_BEEF);
            check_val("zero_after_rst", bus.out, 32'd0);
        end

        // Reference load and compute with a wrap on the tenth edge.
        for (int i = 0; i < 9; i++) step(1'b1, ((32'd17 - i[31:0]) << 16) | (32'd8 - i[31:0]));
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 32'd0);
            check_val("c_plan", bus.out, plan_c[i]);
        end

        // Sum of three maximal products truncates modulo 2^32.
        for (int i = 0; i < 9; i++) step(1'b1, 32'hFFFF_FFFF);
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 32'd0);
            check_val("c_ovf", bus.out, 32'hFFFA_0003);
        end

        // Phase switch after a partial load restarts at slot 0 with unwritten slots still zero.
        pulse_reset("rst_part");
        for (int i = 0; i < 4; i++) step(1'b1, {16'(i + 2), 16'(i + 5)});
        for (int i = 0; i < 9; i++) step(1'b0, 32'd0);

        // Load wrap: the tenth word overwrites S0 and the counter then shows 1.
        for (int i = 0; i < 10; i++) step(1'b1, {16'(i * 3 + 1), 16'(i + 11)});
        check_val("wrap_sel", {28'd0, bus.sel_wire}, 32'd1);
        for (int i = 0; i < 9; i++) step(1'b0, 32'd0);

        // Random data, with a mid-compute return to load that keeps storage.
        for (int i = 0; i < 9; i++) step(1'b1, $urandom);
        for (int i = 0; i < 5; i++) step(1'b0, 32'd0);
        for (int i = 0; i < 3; i++) step(1'b1, $urandom);
        for (int i = 0; i < 9; i++) step(1'b0, $urandom);

        check_val("queue_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/dot_product_3x3.md
# dot_product_3x3

Two-phase 3x3 unsigned matrix-product engine. It merges the Dot_product datapath and the Register_32bits nine-slot storage bank into one block.
- Load phase: nine packed words stream in, each carrying one element of matrix A and the matching element of matrix B.
- Compute phase: the block emits the nine elements of C = A×B, one per clock, in row-major order.
- It sits between a host-side word stream and any consumer of the product elements.

## Interface
Parameters: none (fixed 3x3, 16-bit elements, 32-bit results).
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low; clears all state immediately
- data_RW  input  1  phase select: 1 = load (write storage), 0 = compute (read and multiply)
- in  input  32  load word: in[15:0] = A element, in[31:16] = B element (both unsigned)
- out  output  32  registered product element C[i][j]
- sel_wire  output  4  current slot index, 0..8

## Operation
- Storage: nine 32-bit slots, S0..S8. Slot s holds A[s/3][s%3] in bits [15:0] and B[s/3][s%3] in bits [31:16].
- Slot counter: 4 bits, drives sel_wire, counts 0→1→…→8→0. Values 9..15 are never reached.
- Phase restart: the block registers the previous data_RW value. On any rising edge where data_RW differs from its registered value, the counter resets to 0 and that edge acts as cycle 0 of the new phase.
- Load phase (data_RW=1), each rising edge:
  - S[counter] <= in.
  - Counter advances with wrap.
  - out holds its value.
- Compute phase (data_RW=0), each rising edge:
  - out <= C[counter/3][counter%3], where C[i][j] = Σk A[i][k]·B[k][j], k = 0..2.
  - Counter advances with wrap.
  - Storage is unchanged.
- Arithmetic:
  - Unsigned 16x16 multiplies with full 32-bit products.
  - The three-term sum is truncated modulo 2^32; no saturation, no overflow flag.
- Products are formed combinationally from storage. Three multipliers plus an adder tree is sufficient.
- Continuing past slot 8 in either phase wraps to 0:
  - In load, the next word overwrites S0.
  - In compute, C[0][0] is re-emitted.

## Timing
- Reset (asynchronous, on reset=0):
  - counter = 0, out = 0, all slots = 0.
  - Registered data_RW = 1 (load phase).
- Reset release:
  - The first rising edge with reset=1 performs a normal operation at slot 0.
- Load latency:
  - A word presented before rising edge n is stored in slot n (counting from 0 after reset or phase change).
- Compute latency:
  - out reflects C for slot n one edge after the counter shows n, i.e. registered, 1-cycle latency.
  - sel_wire shows the slot being produced on the next edge.
- Mid-operation reset:
  - Asserting reset during load discards all loaded data.
  - Asserting reset during compute zeroes out.
- Phase switch without reset:
  - Allowed. The counter restarts at 0 as described, and storage keeps its contents.
- in is ignored when data_RW=0. No handshake and no stall: one slot per clock.

## Test plan
- Reset: hold reset=0 mid-stream -> out=0, sel_wire=0, and a subsequent compute with no load yields out=0 for all nine cycles.
- Load sequence: data_RW=1; words (b<<16)|a for (a,b) = (8,17),(7,16),(6,15),(5,14),(4,13),(3,12),(2,11),(1,10),(0,9) -> sel_wire steps 0..8, S0=0x00110008 … S8=0x00090000.
- Compute after that load: data_RW=0 for nine edges -> out = 300, 279, 258, 174, 162, 150, 48, 45, 42 in order. A tenth edge wraps to 300.
- Overflow: all slots = 0xFFFFFFFF, compute -> every out = (3·0xFFFE0001) mod 2^32 = 0xFFFA0003.
- Phase switch mid-count: load 4 words, drop data_RW to 0 -> counter restarts at 0. Unwritten slots stay 0. First out = C[0][0] computed from partial data.
- Load wrap: load 10 words -> the tenth overwrites S0, sel_wire returns to 1 afterwards.
